// File: rtl/lock_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lock_sequencer : keypad lock sequencer (program / entry / check / lockout) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lock_sequencer #(
    parameter int CODE_LEN       = 4,
    parameter int MAX_FAIL       = 3,
    parameter int LOCK_CYCLES    = 1000,
    parameter int OPEN_CYCLES    = 500,
    parameter int RESULT_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_strobe,
    input  logic       key_set,
    input  logic       key_clear,
    input  logic       correct_password,
    input  logic       incorrect_password,
    output logic       input_value,
    output logic       store_value,
    output logic       compare,
    output logic       unlocked,
    output logic       lockout,
    output logic [1:0] fail_count,
    output logic [2:0] state
);

    localparam int c_T1      = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
    localparam int c_TMAX    = (c_T1 > RESULT_TIMEOUT) ? c_T1 : RESULT_TIMEOUT;
    localparam int c_TW      = $clog2(c_TMAX + 1);

    localparam logic [3:0]      c_LAST     = 4'(CODE_LEN - 1);
    localparam logic [1:0]      c_MAX_FAIL = 2'(MAX_FAIL);
    localparam logic [c_TW-1:0] c_RES_LD   = c_TW'(RESULT_TIMEOUT - 1);
    localparam logic [c_TW-1:0] c_OPEN_LD  = c_TW'(OPEN_CYCLES - 1);
    localparam logic [c_TW-1:0] c_LOCK_LD  = c_TW'(LOCK_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TONE     = c_TW'(1);

    typedef enum logic [2:0] {
        S_UNSET   = 3'd0,
        S_PROG    = 3'd1,
        S_ARMED   = 3'd2,
        S_ENTRY   = 3'd3,
        S_CHECK   = 3'd4,
        S_OPEN    = 3'd5,
        S_LOCKOUT = 3'd6
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [c_TW-1:0] r_timer;
    logic [1:0]      r_fail;

    logic       w_key_ok;
    logic [1:0] w_fail_inc;
    logic       w_check_fail;

    // Symbol pulses are combinational so they land in the strobe's own cycle.
    assign w_key_ok     = resetn && key_strobe && !key_clear;
    assign store_value  = w_key_ok && (r_state == S_PROG);
    assign input_value  = w_key_ok && ((r_state == S_ARMED) || (r_state == S_ENTRY));
    assign compare      = (r_state == S_CHECK);
    assign unlocked     = (r_state == S_OPEN);
    assign lockout      = (r_state == S_LOCKOUT);
    assign fail_count   = r_fail;
    assign state        = r_state;

    assign w_fail_inc   = (r_fail == 2'd3) ? 2'd3 : r_fail + 2'd1;
    // A simultaneous correct+incorrect answer counts as a failure.
    assign w_check_fail = incorrect_password || ((r_timer == '0) && !correct_password);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_UNSET;
            r_cnt   <= 4'd0;
            r_timer <= '0;
            r_fail  <= 2'd0;
        end else begin
            case (r_state)
                S_UNSET: begin
                    if (key_set) begin
                        r_state <= S_PROG;
                        r_cnt   <= 4'd0;
                    end
                end
                S_PROG: begin
                    if (key_clear) begin
                        r_state <= S_UNSET;
                        r_cnt   <= 4'd0;
                    end else if (key_strobe) begin
                        if (r_cnt == c_LAST) begin
                            r_state <= S_ARMED;
                            r_cnt   <= 4'd0;
                            r_fail  <= 2'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                S_ARMED: begin
                    if (key_strobe && !key_clear) begin
                        if (c_LAST == 4'd0) begin
                            r_state <= S_CHECK;
                            r_cnt   <= 4'd0;
                            r_timer <= c_RES_LD;
                        end else begin
                            r_state <= S_ENTRY;
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                S_ENTRY: begin
                    if (key_clear) begin
                        r_state <= S_ARMED;
                        r_cnt   <= 4'd0;
                    end else if (key_strobe) begin
                        if (r_cnt == c_LAST) begin
                            r_state <= S_CHECK;
                            r_cnt   <= 4'd0;
                            r_timer <= c_RES_LD;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_check_fail) begin
                        r_fail <= w_fail_inc;
                        if (w_fail_inc >= c_MAX_FAIL) begin
                            r_state <= S_LOCKOUT;
                            r_timer <= c_LOCK_LD;
                        end else begin
                            r_state <= S_ARMED;
                        end
                    end else if (correct_password) begin
                        r_state <= S_OPEN;
                        r_fail  <= 2'd0;
                        r_timer <= c_OPEN_LD;
                    end else begin
                        r_timer <= r_timer - c_TONE;
                    end
                end
                S_OPEN: begin
                    if (key_clear) begin
                        r_state <= S_ARMED;
                    end else if (key_set) begin
                        r_state <= S_PROG;
                        r_cnt   <= 4'd0;
                    end else if (r_timer == '0) begin
                        r_state <= S_ARMED;
                    end else begin
                        r_timer <= r_timer - c_TONE;
                    end
                end
                S_LOCKOUT: begin
                    if (r_timer == '0) begin
                        r_state <= S_ARMED;
                        r_fail  <= 2'd0;
                    end else begin
                        r_timer <= r_timer - c_TONE;
                    end
                end
                default: begin
                    r_state <= S_UNSET;
                    r_cnt   <= 4'd0;
                    r_timer <= '0;
                    r_fail  <= 2'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lock_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lock_sequencer : directed self-checking bench for lock_sequencer        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_lock_sequencer;

    localparam logic [2:0] c_UNSET = 3'd0, c_PROG = 3'd1, c_ARMED = 3'd2,
                           c_ENTRY = 3'd3, c_CHECK = 3'd4, c_OPEN = 3'd5,
                           c_LOCK = 3'd6;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       key_strobe = 1'b0, key_set = 1'b0, key_clear = 1'b0;
    logic       correct_password = 1'b0, incorrect_password = 1'b0;
    logic       input_value, store_value, compare, unlocked, lockout;
    logic [1:0] fail_count;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;
    bit exp_q[$];   // 1 = store_value pulse expected, 0 = input_value pulse expected

    lock_sequencer dut (
        .clk(clk), .resetn(resetn), .key_strobe(key_strobe), .key_set(key_set),
        .key_clear(key_clear), .correct_password(correct_password),
        .incorrect_password(incorrect_password), .input_value(input_value),
        .store_value(store_value), .compare(compare), .unlocked(unlocked),
        .lockout(lockout), .fail_count(fail_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every capture pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (store_value || input_value) begin
            if (store_value && input_value)
                chk("pulse_exclusive", 1, 0);
            else if (exp_q.size() == 0)
                chk("unexpected_pulse", int'(store_value), -1);
            else
                chk("pulse_kind", int'(store_value), int'(exp_q.pop_front()));
        end
        if (compare && (store_value || input_value))
            chk("compare_exclusive", 1, 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input bit expect_pulse, input bit kind);
        if (expect_pulse) exp_q.push_back(kind);
        key_strobe = 1'b1;
        tick();
        key_strobe = 1'b0;
    endtask

    task automatic enter4();
        for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
    endtask

    initial begin
        int n;
        // Reset state
        tick(); tick();
        chk("rst_state", int'(state), int'(c_UNSET));
        chk("rst_unlocked", int'(unlocked), 0);
        chk("rst_lockout", int'(lockout), 0);
        chk("rst_compare", int'(compare), 0);
        chk("rst_fail", int'(fail_count), 0);
        resetn = 1'b1;
        tick();

        // UNSET ignores strobes
        strobe(1'b0, 1'b0);
        chk("unset_ignore", int'(state), int'(c_UNSET));

        // Programming
        key_set = 1'b1; tick(); key_set = 1'b0;
        chk("prog_enter", int'(state), int'(c_PROG));
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b1);
        chk("prog_3", int'(state), int'(c_PROG));
        strobe(1'b1, 1'b1);
        chk("prog_armed", int'(state), int'(c_ARMED));
        chk("prog_fail", int'(fail_count), 0);

        // Correct entry
        strobe(1'b1, 1'b0);
        chk("entry_1", int'(state), int'(c_ENTRY));
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
        chk("check_state", int'(state), int'(c_CHECK));
        chk("compare_rise", int'(compare), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("compare_hold", int'(compare), 1);
        end
        correct_password = 1'b1; tick(); correct_password = 1'b0;
        chk("open_state", int'(state), int'(c_OPEN));
        chk("compare_fall", int'(compare), 0);
        n = 0;
        while (unlocked && n < 2000) begin n++; tick(); end
        chk("open_cycles", n, 500);
        chk("open_to_armed", int'(state), int'(c_ARMED));

        // Three failures -> lockout (second has both results asserted)
        for (int i = 1; i <= 3; i++) begin
            enter4();
            chk("fail_check", int'(state), int'(c_CHECK));
            incorrect_password = 1'b1;
            correct_password   = (i == 2);
            tick();
            incorrect_password = 1'b0;
            correct_password   = 1'b0;
            chk("fail_count", int'(fail_count), i);
            chk("fail_next", int'(state), (i < 3) ? int'(c_ARMED) : int'(c_LOCK));
        end
        chk("lockout_flag", int'(lockout), 1);
        n = 0;
        key_strobe = 1'b1;
        while (lockout && n < 2000) begin
            key_set = n[3];
            n++;
            tick();
        end
        key_strobe = 1'b0;
        key_set = 1'b0;
        chk("lock_cycles", n, 1000);
        chk("lock_exit", int'(state), int'(c_ARMED));
        chk("lock_fail_clr", int'(fail_count), 0);

        // Result timeout
        enter4();
        n = 0;
        while (compare && n < 100) begin n++; tick(); end
        chk("timeout_cycles", n, 16);
        chk("timeout_fail", int'(fail_count), 1);
        chk("timeout_armed", int'(state), int'(c_ARMED));

        // key_clear beats a coincident strobe in ENTRY
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        chk("clr_entry", int'(state), int'(c_ENTRY));
        key_clear = 1'b1;
        strobe(1'b0, 1'b0);
        key_clear = 1'b0;
        chk("clr_armed", int'(state), int'(c_ARMED));
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
        chk("clr_restart", int'(state), int'(c_ENTRY));
        strobe(1'b1, 1'b0);
        chk("clr_check", int'(state), int'(c_CHECK));
        correct_password = 1'b1; tick(); correct_password = 1'b0;
        chk("open2", int'(state), int'(c_OPEN));
        chk("open2_fail", int'(fail_count), 0);
        key_clear = 1'b1; tick(); key_clear = 1'b0;
        chk("open_clear", int'(state), int'(c_ARMED));

        // Reset during OPEN
        enter4();
        correct_password = 1'b1; tick(); correct_password = 1'b0;
        tick(); tick();
        chk("open3", int'(unlocked), 1);
        resetn = 1'b0; tick(); resetn = 1'b1;
        chk("rst_open_unl", int'(unlocked), 0);
        chk("rst_open_state", int'(state), int'(c_UNSET));
        strobe(1'b0, 1'b0);
        chk("rst_ignore", int'(state), int'(c_UNSET));
        key_set = 1'b1; tick(); key_set = 1'b0;
        chk("rst_prog", int'(state), int'(c_PROG));
        key_clear = 1'b1; tick(); key_clear = 1'b0;
        chk("prog_clear", int'(state), int'(c_UNSET));

        tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 The block SHALL have parameter CODE_LEN, default 4, meaning the number of symbols per password, range 1..15.
REQ-002 The block SHALL have parameter MAX_FAIL, default 3, meaning the number of consecutive failed checks that triggers lockout, range 1..3.
REQ-003 The block SHALL have parameter LOCK_CYCLES, default 1000, meaning the lockout duration in clocks.
REQ-004 The block SHALL have parameter OPEN_CYCLES, default 500, meaning the unlocked duration in clocks.
REQ-005 The block SHALL have parameter RESULT_TIMEOUT, default 16, meaning the clocks to wait for a checker result.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-007 The block SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-008 The block SHALL have port key_strobe, input, 1 bit: one-cycle pulse indicating the switches hold a new symbol.
REQ-009 The block SHALL have port key_set, input, 1 bit: request to program a new password.
REQ-010 The block SHALL have port key_clear, input, 1 bit: request to abort the current entry or programming.
REQ-011 The block SHALL have port correct_password, input, 1 bit: match result from the checker.
REQ-012 The block SHALL have port incorrect_password, input, 1 bit: mismatch result from the checker.
REQ-013 The block SHALL have port input_value, output, 1 bit: one-cycle pulse telling the checker to capture the symbol as entry.
REQ-014 The block SHALL have port store_value, output, 1 bit: one-cycle pulse telling the checker to capture the symbol as password.
REQ-015 The block SHALL have port compare, output, 1 bit: held high while a check is in progress.
REQ-016 The block SHALL have port unlocked, output, 1 bit: lock is open.
REQ-017 The block SHALL have port lockout, output, 1 bit: entry is disabled.
REQ-018 The block SHALL have port fail_count, output, 2 bits: consecutive failed checks.
REQ-019 The block SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-020 The FSM SHALL use states UNSET=0, PROG=1, ARMED=2, ENTRY=3, CHECK=4, OPEN=5, LOCKOUT=6; any other encoding SHALL go to UNSET on the next clock.
REQ-021 In UNSET, key_set SHALL transition to PROG with the symbol counter cleared; all other inputs SHALL be ignored.
REQ-022 In PROG, each key_strobe SHALL produce a store_value pulse in the same cycle as the key_strobe and increment the symbol counter.
REQ-023 In PROG, once the symbol counter reaches CODE_LEN, the FSM SHALL go to ARMED on the next clock with fail_count cleared.
REQ-024 In ARMED, key_strobe SHALL pulse input_value, set the counter to 1, and go to ENTRY; if CODE_LEN=1, it SHALL go directly to CHECK instead.
REQ-025 In ENTRY, each key_strobe SHALL pulse input_value and increment the counter.
REQ-026 In ENTRY, when the counter reaches CODE_LEN, the FSM SHALL go to CHECK, with compare asserted from the first CHECK cycle.
REQ-027 In CHECK, compare SHALL stay high until a result is seen or RESULT_TIMEOUT cycles elapse.
REQ-028 In CHECK, key_strobe, key_set and key_clear SHALL be ignored.
REQ-029 In CHECK, correct_password SHALL go to OPEN and clear fail_count.
REQ-030 In CHECK, incorrect_password or a timeout SHALL increment fail_count, saturating at 3.
REQ-031 After a failed check, the FSM SHALL go to LOCKOUT if the new fail_count is greater than or equal to MAX_FAIL, else to ARMED.
REQ-032 If correct_password and incorrect_password are asserted together, the result SHALL be treated as a failure.
REQ-033 In OPEN, unlocked SHALL be 1 for OPEN_CYCLES clocks, then the FSM SHALL go to ARMED.
REQ-034 In OPEN, key_set SHALL go to PROG immediately; key_clear SHALL go to ARMED immediately.
REQ-035 In LOCKOUT, lockout SHALL be 1 and all keys SHALL be ignored for LOCK_CYCLES clocks.
REQ-036 On leaving LOCKOUT, the FSM SHALL go to ARMED with fail_count cleared.
REQ-037 key_clear in ENTRY SHALL go to ARMED with the counter cleared and no compare.
REQ-038 key_clear in PROG SHALL go to UNSET.
REQ-039 key_clear SHALL have priority over a coincident key_strobe.
REQ-040 input_value, store_value and compare SHALL never be high in the same cycle.
REQ-041 input_value and store_value SHALL be high for at most one cycle per key_strobe.
REQ-042 The timer SHALL be a single counter, reloaded on entry to CHECK, OPEN and LOCKOUT, wide enough for the largest parameter.

Reset
REQ-043 When resetn=0 at a clock edge, the block SHALL set state=UNSET, counter=0, timer=0, fail_count=0, and all outputs to 0 on that edge, including mid-CHECK, OPEN or LOCKOUT.
REQ-044 Reset SHALL override every other input.

Verification
REQ-045 Reset, key_set, then 4 key_strobes -> 4 store_value pulses, one per strobe; state=ARMED after the 4th.
REQ-046 ARMED, 4 key_strobes, correct_password 3 cycles after compare rises -> compare falls, unlocked=1 for exactly 500 cycles, then state=ARMED.
REQ-047 Three entries each answered by incorrect_password -> fail_count 1,2,3; lockout=1 for 1000 cycles; strobes ignored; then ARMED with fail_count=0.
REQ-048 CHECK with no result -> compare high for 16 cycles, then fail_count increments.
REQ-049 ENTRY after 2 strobes, key_clear together with key_strobe -> no input_value, state=ARMED, counter=0.
REQ-050 resetn=0 during OPEN -> next cycle unlocked=0, state=UNSET; key_strobe ignored until key_set.
